map_table: RTL and testbench
============================

Name: map_table

Overview:
- Register-rename map table for a 2-wide out-of-order core; 32 architectural registers (AR), 7-bit physical register (PR) tags.
- Per AR it holds the current PR tag and a ready bit.
- Between dispatch (ROB/free list) and the reservation stations (RS): it renames up to two instructions' sources and destinations per cycle.
- Up to 4 CDB completions per cycle mark entries ready.

Parameters:
- CDB_WIDTH, 3: width of cdb_broadcast, which is a count of valid CDB slots (0..4).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rob_dispatch_num  in  2  instructions dispatched this cycle (0, 1 or 2)
- fl_pr0, fl_pr1  in  7 each  new PR tags from the free list for inst0 / inst1
- rob_ar_a_valid, rob_ar_b_valid  in  1 each  inst0 / inst1 has a destination
- rob_ar_a1_valid, rob_ar_a2_valid  in  1 each  inst0 source 1 / 2 valid
- rob_ar_b1_valid, rob_ar_b2_valid  in  1 each  inst1 source 1 / 2 valid
- rob_ar_a, rob_ar_b  in  5 each  destination AR of inst0 / inst1
- rob_ar_a1, rob_ar_a2  in  5 each  source ARs of inst0
- rob_ar_b1, rob_ar_b2  in  5 each  source ARs of inst1
- cdb_broadcast  in  CDB_WIDTH  number of valid CDB slots; slots 0..n-1 are valid
- cdb_pr_tag0..cdb_pr_tag3  in  7 each  completing PR tag per slot
- cdb_ar_tag0..cdb_ar_tag3  in  5 each  AR written by that completion
- rob_p0told, rob_p1told  out  7 each  previous PR mapping of inst0 / inst1 destination
- rs_pr_a1, rs_pr_a2, rs_pr_b1, rs_pr_b2  out  7 each  renamed source PR tags
- rs_pr_a1_ready, rs_pr_a2_ready, rs_pr_b1_ready, rs_pr_b2_ready  out  1 each  source value available

Behaviour:
- State: 32 entries, each holding a 7-bit tag and a ready bit.
- Reset (synchronous, on the clock edge while reset=1): entry i gets tag = i and ready = 1; this overrides dispatch and CDB.
- All outputs are combinational reads of the current state plus the current inputs; zero latency. Updates take effect at the next posedge.
- rob_p0told = tag[rob_ar_a].
- rob_p1told = fl_pr0 if inst0 writes and rob_ar_b == rob_ar_a; otherwise tag[rob_ar_b].
- rs_pr_a1 / rs_pr_a2 = tag / ready of rob_ar_a1 / rob_ar_a2.
- rs_pr_b1 / rs_pr_b2: if inst0 writes and the source AR equals rob_ar_a, output fl_pr0 with ready 0 (intra-group forwarding). Otherwise output the table tag and ready.
- "inst0 writes" means rob_dispatch_num >= 1 and rob_ar_a_valid.
- "inst1 writes" means rob_dispatch_num == 2 and rob_ar_b_valid. rob_dispatch_num = 3 is treated as 2.
- Outputs whose valid bit is 0 are don't-care but still driven from the table.
- Clock-edge update priority, lowest to highest:
  1. CDB: for each slot k < cdb_broadcast, if tag[cdb_ar_tagk] == cdb_pr_tagk, set ready = 1. Stale tags are ignored.
  2. inst0 write: tag[rob_ar_a] = fl_pr0, ready = 0.
  3. inst1 write: tag[rob_ar_b] = fl_pr1, ready = 0. If rob_ar_b == rob_ar_a, inst1's write wins.
- A dispatch write overrides a CDB ready on the same AR in the same cycle.
- Slots with k >= cdb_broadcast are ignored regardless of their tag values.
- There is no same-cycle CDB-to-output bypass unless the optional feature is enabled; the RS is responsible for snooping the CDB.
- AR 31 receives no special treatment.

Optional Feature:
- Macro MT_CDB_BYPASS_EN.
- When defined: a source read whose table tag equals a valid CDB slot's cdb_pr_tag reports ready = 1 in the same cycle. Intra-group forwarded sources stay ready 0.
- When undefined: ready bits reflect registered state only.

Test Plan:
- Reset, then reads with rob_ar_a=2 and sources 5/6/7/8 -> rob_p0told=2; rs_pr = 5/6/7/8, all ready=1.
- Dispatch 2 with ar_a=3, ar_b=4, fl_pr0=32, fl_pr1=33 -> told 3/4. Next cycle, sources 3/4 -> rs_pr 32/33 with ready=0; source 5 -> 5 with ready=1.
- Dispatch 1 with ar_a=9, ar_b=10, fl_pr0=34 -> told=9; afterwards r9 maps to 34 and r10 remains 10.
- cdb_broadcast=2, pr tags 32/33, ar tags 3/4 -> next cycle r3=32 ready=1 and r4=33 ready=1. The same values with cdb_broadcast=0 leave r3/r4 not ready.
- Same-group dependency: ar_a=7, rob_ar_b1=7, fl_pr0=40 -> rs_pr_b1=40, ready=0. With ar_b=7 and fl_pr1=41 also set -> rob_p1told=40 and r7 maps to 41 afterwards.
- Stale CDB tag: r3 remapped to 36, then the CDB broadcasts pr 32 for ar 3 -> r3 stays 36, not ready. Reset asserted mid-run -> identity map, all ready.

Source files
------------

// File: rtl/map_table.sv
// Register-rename map table: 32 AR entries of {PR tag, ready}, 2-wide rename, 4-slot CDB wakeup.
// Optional same-cycle CDB-to-source ready bypass enabled by defining MT_CDB_BYPASS_EN.
module map_table #(
   parameter int CDB_WIDTH = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [1:0]           rob_dispatch_num,
   input  logic [6:0]           fl_pr0,
   input  logic [6:0]           fl_pr1,
   input  logic                 rob_ar_a_valid,
   input  logic                 rob_ar_b_valid,
   input  logic                 rob_ar_a1_valid,
   input  logic                 rob_ar_a2_valid,
   input  logic                 rob_ar_b1_valid,
   input  logic                 rob_ar_b2_valid,
   input  logic [4:0]           rob_ar_a,
   input  logic [4:0]           rob_ar_b,
   input  logic [4:0]           rob_ar_a1,
   input  logic [4:0]           rob_ar_a2,
   input  logic [4:0]           rob_ar_b1,
   input  logic [4:0]           rob_ar_b2,
   input  logic [CDB_WIDTH-1:0] cdb_broadcast,
   input  logic [6:0]           cdb_pr_tag0,
   input  logic [6:0]           cdb_pr_tag1,
   input  logic [6:0]           cdb_pr_tag2,
   input  logic [6:0]           cdb_pr_tag3,
   input  logic [4:0]           cdb_ar_tag0,
   input  logic [4:0]           cdb_ar_tag1,
   input  logic [4:0]           cdb_ar_tag2,
   input  logic [4:0]           cdb_ar_tag3,
   output logic [6:0]           rob_p0told,
   output logic [6:0]           rob_p1told,
   output logic [6:0]           rs_pr_a1,
   output logic [6:0]           rs_pr_a2,
   output logic [6:0]           rs_pr_b1,
   output logic [6:0]           rs_pr_b2,
   output logic                 rs_pr_a1_ready,
   output logic                 rs_pr_a2_ready,
   output logic                 rs_pr_b1_ready,
   output logic                 rs_pr_b2_ready
);

   logic [6:0]  r_tag [32];
   logic [31:0] r_ready;

   logic       w_inst0_wr;
   logic       w_inst1_wr;
   logic [3:0] w_cdb_valid;
   logic [6:0] w_cdb_pr [4];
   logic [4:0] w_cdb_ar [4];
   logic [4:0] w_src_ar [4];
   logic [3:0] w_src_fwd;
   logic [6:0] w_src_tag [4];
   logic [3:0] w_src_rdy;

   // Source valid bits are don't-care: sources are always renamed from the table.
   logic       w_unused_valids;
   assign w_unused_valids = ^{rob_ar_a1_valid, rob_ar_a2_valid, rob_ar_b1_valid, rob_ar_b2_valid};

   assign w_inst0_wr = (rob_dispatch_num != 2'd0) && rob_ar_a_valid;
   assign w_inst1_wr = rob_dispatch_num[1] && rob_ar_b_valid;

   assign w_cdb_pr[0] = cdb_pr_tag0;
   assign w_cdb_pr[1] = cdb_pr_tag1;
   assign w_cdb_pr[2] = cdb_pr_tag2;
   assign w_cdb_pr[3] = cdb_pr_tag3;
   assign w_cdb_ar[0] = cdb_ar_tag0;
   assign w_cdb_ar[1] = cdb_ar_tag1;
   assign w_cdb_ar[2] = cdb_ar_tag2;
   assign w_cdb_ar[3] = cdb_ar_tag3;

   assign w_src_ar[0] = rob_ar_a1;
   assign w_src_ar[1] = rob_ar_a2;
   assign w_src_ar[2] = rob_ar_b1;
   assign w_src_ar[3] = rob_ar_b2;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_cdb
         assign w_cdb_valid[gi] = (32'(cdb_broadcast) > gi);
      end

      for (genvar gi = 0; gi < 4; gi++) begin : g_src
         logic w_hit;
`ifdef MT_CDB_BYPASS_EN
         assign w_hit = |(w_cdb_valid & {w_cdb_pr[3] == r_tag[w_src_ar[gi]],
                                         w_cdb_pr[2] == r_tag[w_src_ar[gi]],
                                         w_cdb_pr[1] == r_tag[w_src_ar[gi]],
                                         w_cdb_pr[0] == r_tag[w_src_ar[gi]]});
`else
         assign w_hit = 1'b0;
`endif
         // Only inst1 sources can depend on inst0's destination in the same group.
         if (gi >= 2) begin : g_fwd
            assign w_src_fwd[gi] = w_inst0_wr && (w_src_ar[gi] == rob_ar_a);
         end else begin : g_nofwd
            assign w_src_fwd[gi] = 1'b0;
         end
         assign w_src_tag[gi] = w_src_fwd[gi] ? fl_pr0 : r_tag[w_src_ar[gi]];
         assign w_src_rdy[gi] = w_src_fwd[gi] ? 1'b0 : (r_ready[w_src_ar[gi]] | w_hit);
      end
   endgenerate

   assign rob_p0told = r_tag[rob_ar_a];
   assign rob_p1told = (w_inst0_wr && (rob_ar_b == rob_ar_a)) ? fl_pr0 : r_tag[rob_ar_b];

   assign rs_pr_a1       = w_src_tag[0];
   assign rs_pr_a2       = w_src_tag[1];
   assign rs_pr_b1       = w_src_tag[2];
   assign rs_pr_b2       = w_src_tag[3];
   assign rs_pr_a1_ready = w_src_rdy[0];
   assign rs_pr_a2_ready = w_src_rdy[1];
   assign rs_pr_b1_ready = w_src_rdy[2];
   assign rs_pr_b2_ready = w_src_rdy[3];

   // Later assignments win: CDB wakeup, then inst0 write, then inst1 write.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            r_tag[i] <= 7'(i);
         end
         r_ready <= '1;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (w_cdb_valid[k] && (r_tag[w_cdb_ar[k]] == w_cdb_pr[k])) begin
               r_ready[w_cdb_ar[k]] <= 1'b1;
            end
         end
         if (w_inst0_wr) begin
            r_tag[rob_ar_a]   <= fl_pr0;
            r_ready[rob_ar_a] <= 1'b0;
         end
         if (w_inst1_wr) begin
            r_tag[rob_ar_b]   <= fl_pr1;
            r_ready[rob_ar_b] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_map_table.sv
// Directed bench for map_table: rename reads, dispatch writes, CDB wakeup, forwarding, reset.
module tb_map_table;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] rob_dispatch_num;
   logic [6:0] fl_pr0, fl_pr1;
   logic       rob_ar_a_valid, rob_ar_b_valid;
   logic       rob_ar_a1_valid, rob_ar_a2_valid, rob_ar_b1_valid, rob_ar_b2_valid;
   logic [4:0] rob_ar_a, rob_ar_b, rob_ar_a1, rob_ar_a2, rob_ar_b1, rob_ar_b2;
   logic [2:0] cdb_broadcast;
   logic [6:0] cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3;
   logic [4:0] cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3;
   logic [6:0] rob_p0told, rob_p1told, rs_pr_a1, rs_pr_a2, rs_pr_b1, rs_pr_b2;
   logic       rs_pr_a1_ready, rs_pr_a2_ready, rs_pr_b1_ready, rs_pr_b2_ready;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   map_table #(.CDB_WIDTH(3)) dut (
      .clock(clock), .reset(reset), .rob_dispatch_num(rob_dispatch_num),
      .fl_pr0(fl_pr0), .fl_pr1(fl_pr1),
      .rob_ar_a_valid(rob_ar_a_valid), .rob_ar_b_valid(rob_ar_b_valid),
      .rob_ar_a1_valid(rob_ar_a1_valid), .rob_ar_a2_valid(rob_ar_a2_valid),
      .rob_ar_b1_valid(rob_ar_b1_valid), .rob_ar_b2_valid(rob_ar_b2_valid),
      .rob_ar_a(rob_ar_a), .rob_ar_b(rob_ar_b),
      .rob_ar_a1(rob_ar_a1), .rob_ar_a2(rob_ar_a2),
      .rob_ar_b1(rob_ar_b1), .rob_ar_b2(rob_ar_b2),
      .cdb_broadcast(cdb_broadcast),
      .cdb_pr_tag0(cdb_pr_tag0), .cdb_pr_tag1(cdb_pr_tag1),
      .cdb_pr_tag2(cdb_pr_tag2), .cdb_pr_tag3(cdb_pr_tag3),
      .cdb_ar_tag0(cdb_ar_tag0), .cdb_ar_tag1(cdb_ar_tag1),
      .cdb_ar_tag2(cdb_ar_tag2), .cdb_ar_tag3(cdb_ar_tag3),
      .rob_p0told(rob_p0told), .rob_p1told(rob_p1told),
      .rs_pr_a1(rs_pr_a1), .rs_pr_a2(rs_pr_a2), .rs_pr_b1(rs_pr_b1), .rs_pr_b2(rs_pr_b2),
      .rs_pr_a1_ready(rs_pr_a1_ready), .rs_pr_a2_ready(rs_pr_a2_ready),
      .rs_pr_b1_ready(rs_pr_b1_ready), .rs_pr_b2_ready(rs_pr_b2_ready)
   );

   task automatic clear_inputs();
      reset = 1'b0;
      rob_dispatch_num = 2'd0;
      fl_pr0 = '0; fl_pr1 = '0;
      rob_ar_a_valid = 1'b0; rob_ar_b_valid = 1'b0;
      rob_ar_a1_valid = 1'b1; rob_ar_a2_valid = 1'b1;
      rob_ar_b1_valid = 1'b1; rob_ar_b2_valid = 1'b1;
      rob_ar_a = '0; rob_ar_b = '0;
      rob_ar_a1 = '0; rob_ar_a2 = '0; rob_ar_b1 = '0; rob_ar_b2 = '0;
      cdb_broadcast = '0;
      cdb_pr_tag0 = '0; cdb_pr_tag1 = '0; cdb_pr_tag2 = '0; cdb_pr_tag3 = '0;
      cdb_ar_tag0 = '0; cdb_ar_tag1 = '0; cdb_ar_tag2 = '0; cdb_ar_tag3 = '0;
   endtask

   // Apply the currently driven inputs on one rising edge, return at the falling edge.
   task automatic tick();
      @(posedge clock);
      @(negedge clock);
      clear_inputs();
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      clear_inputs();
      rob_ar_a = 5'd2; rob_ar_b = 5'd0;
      rob_ar_a1 = 5'd5; rob_ar_a2 = 5'd6; rob_ar_b1 = 5'd7; rob_ar_b2 = 5'd8;
      #1;
      $display("reset read: told=%0d a1=%0d a2=%0d b1=%0d b2=%0d", rob_p0told, rs_pr_a1, rs_pr_a2, rs_pr_b1, rs_pr_b2);
      checks++; if (rob_p0told !== 7'd2) begin failures++; $display("FAIL reset_p0told got=%0d exp=2", rob_p0told); end
      checks++; if (rob_p1told !== 7'd0) begin failures++; $display("FAIL reset_p1told got=%0d exp=0", rob_p1told); end
      checks++; if ({rs_pr_a1, rs_pr_a2, rs_pr_b1, rs_pr_b2} !== {7'd5, 7'd6, 7'd7, 7'd8}) begin
         failures++; $display("FAIL reset_tags got=%0d/%0d/%0d/%0d exp=5/6/7/8", rs_pr_a1, rs_pr_a2, rs_pr_b1, rs_pr_b2); end
      checks++; if ({rs_pr_a1_ready, rs_pr_a2_ready, rs_pr_b1_ready, rs_pr_b2_ready} !== 4'b1111) begin
         failures++; $display("FAIL reset_ready got=%b%b%b%b exp=1111", rs_pr_a1_ready, rs_pr_a2_ready, rs_pr_b1_ready, rs_pr_b2_ready); end
   endtask

   task automatic test_dispatch2();
      rob_dispatch_num = 2'd2; rob_ar_a_valid = 1'b1; rob_ar_b_valid = 1'b1;
      rob_ar_a = 5'd3; rob_ar_b = 5'd4; fl_pr0 = 7'd32; fl_pr1 = 7'd33;
      #1;
      $display("dispatch2: p0told=%0d p1told=%0d", rob_p0told, rob_p1told);
      checks++; if (rob_p0told !== 7'd3) begin failures++; $display("FAIL d2_p0told got=%0d exp=3", rob_p0told); end
      checks++; if (rob_p1told !== 7'd4) begin failures++; $display("FAIL d2_p1told got=%0d exp=4", rob_p1told); end
      tick();
      rob_ar_a1 = 5'd3; rob_ar_a2 = 5'd4; rob_ar_b1 = 5'd5;
      #1;
      $display("after d2: a1=%0d/%b a2=%0d/%b b1=%0d/%b", rs_pr_a1, rs_pr_a1_ready, rs_pr_a2, rs_pr_a2_ready, rs_pr_b1, rs_pr_b1_ready);
      checks++; if ({rs_pr_a1, rs_pr_a1_ready} !== {7'd32, 1'b0}) begin failures++; $display("FAIL d2_r3 got=%0d/%b exp=32/0", rs_pr_a1, rs_pr_a1_ready); end
      checks++; if ({rs_pr_a2, rs_pr_a2_ready} !== {7'd33, 1'b0}) begin failures++; $display("FAIL d2_r4 got=%0d/%b exp=33/0", rs_pr_a2, rs_pr_a2_ready); end
      checks++; if ({rs_pr_b1, rs_pr_b1_ready} !== {7'd5, 1'b1}) begin failures++; $display("FAIL d2_r5 got=%0d/%b exp=5/1", rs_pr_b1, rs_pr_b1_ready); end
   endtask

   task automatic test_dispatch1();
      rob_dispatch_num = 2'd1; rob_ar_a_valid = 1'b1; rob_ar_b_valid = 1'b1;
      rob_ar_a = 5'd9; rob_ar_b = 5'd10; fl_pr0 = 7'd34; fl_pr1 = 7'd35;
      #1;
      $display("dispatch1: p0told=%0d", rob_p0told);
      checks++; if (rob_p0told !== 7'd9) begin failures++; $display("FAIL d1_p0told got=%0d exp=9", rob_p0told); end
      tick();
      rob_ar_a1 = 5'd9; rob_ar_a2 = 5'd10;
      #1;
      $display("after d1: r9=%0d/%b r10=%0d/%b", rs_pr_a1, rs_pr_a1_ready, rs_pr_a2, rs_pr_a2_ready);
      checks++; if ({rs_pr_a1, rs_pr_a1_ready} !== {7'd34, 1'b0}) begin failures++; $display("FAIL d1_r9 got=%0d/%b exp=34/0", rs_pr_a1, rs_pr_a1_ready); end
      checks++; if ({rs_pr_a2, rs_pr_a2_ready} !== {7'd10, 1'b1}) begin failures++; $display("FAIL d1_r10 got=%0d/%b exp=10/1", rs_pr_a2, rs_pr_a2_ready); end
   endtask

   task automatic test_cdb();
      // Zero valid slots: nothing wakes up.
      cdb_broadcast = 3'd0;
      cdb_pr_tag0 = 7'd32; cdb_ar_tag0 = 5'd3; cdb_pr_tag1 = 7'd33; cdb_ar_tag1 = 5'd4;
      tick();
      rob_ar_a1 = 5'd3; rob_ar_a2 = 5'd4;
      #1;
      $display("cdb n=0: r3=%0d/%b r4=%0d/%b", rs_pr_a1, rs_pr_a1_ready, rs_pr_a2, rs_pr_a2_ready);
      checks++; if ({rs_pr_a1_ready, rs_pr_a2_ready} !== 2'b00) begin failures++; $display("FAIL cdb0_ready got=%b%b exp=00", rs_pr_a1_ready, rs_pr_a2_ready); end
      // Two valid slots; slot 2 carries a matching tag but is beyond the count.
      cdb_broadcast = 3'd2;
      cdb_pr_tag0 = 7'd32; cdb_ar_tag0 = 5'd3; cdb_pr_tag1 = 7'd33; cdb_ar_tag1 = 5'd4;
      cdb_pr_tag2 = 7'd34; cdb_ar_tag2 = 5'd9;
      tick();
      rob_ar_a1 = 5'd3; rob_ar_a2 = 5'd4; rob_ar_b1 = 5'd9;
      #1;
      $display("cdb n=2: r3=%0d/%b r4=%0d/%b r9=%0d/%b", rs_pr_a1, rs_pr_a1_ready, rs_pr_a2, rs_pr_a2_ready, rs_pr_b1, rs_pr_b1_ready);
      checks++; if ({rs_pr_a1, rs_pr_a1_ready} !== {7'd32, 1'b1}) begin failures++; $display("FAIL cdb2_r3 got=%0d/%b exp=32/1", rs_pr_a1, rs_pr_a1_ready); end
      checks++; if ({rs_pr_a2, rs_pr_a2_ready} !== {7'd33, 1'b1}) begin failures++; $display("FAIL cdb2_r4 got=%0d/%b exp=33/1", rs_pr_a2, rs_pr_a2_ready); end
      checks++; if ({rs_pr_b1, rs_pr_b1_ready} !== {7'd34, 1'b0}) begin failures++; $display("FAIL cdb2_slot2_ignored got=%0d/%b exp=34/0", rs_pr_b1, rs_pr_b1_ready); end
   endtask

   task automatic test_group_dep();
      rob_dispatch_num = 2'd1; rob_ar_a_valid = 1'b1; rob_ar_a = 5'd7; fl_pr0 = 7'd40;
      rob_ar_a1 = 5'd7; rob_ar_b1 = 5'd7; rob_ar_b2 = 5'd8;
      #1;
      $display("group dep: a1=%0d/%b b1=%0d/%b b2=%0d/%b", rs_pr_a1, rs_pr_a1_ready, rs_pr_b1, rs_pr_b1_ready, rs_pr_b2, rs_pr_b2_ready);
      checks++; if ({rs_pr_b1, rs_pr_b1_ready} !== {7'd40, 1'b0}) begin failures++; $display("FAIL dep_b1 got=%0d/%b exp=40/0", rs_pr_b1, rs_pr_b1_ready); end
      checks++; if ({rs_pr_a1, rs_pr_a1_ready} !== {7'd7, 1'b1}) begin failures++; $display("FAIL dep_a1_nofwd got=%0d/%b exp=7/1", rs_pr_a1, rs_pr_a1_ready); end
      checks++; if ({rs_pr_b2, rs_pr_b2_ready} !== {7'd8, 1'b1}) begin failures++; $display("FAIL dep_b2 got=%0d/%b exp=8/1", rs_pr_b2, rs_pr_b2_ready); end
      // No forwarding when inst0 has no destination.
      rob_ar_a_valid = 1'b0;
      #1;
      checks++; if ({rs_pr_b1, rs_pr_b1_ready} !== {7'd7, 1'b1}) begin failures++; $display("FAIL dep_nowrite_b1 got=%0d/%b exp=7/1", rs_pr_b1, rs_pr_b1_ready); end
      rob_ar_a_valid = 1'b1;
      rob_dispatch_num = 2'd2; rob_ar_b_valid = 1'b1; rob_ar_b = 5'd7; fl_pr1 = 7'd41;
      #1;
      $display("group waw: p0told=%0d p1told=%0d", rob_p0told, rob_p1told);
      checks++; if (rob_p0told !== 7'd7) begin failures++; $display("FAIL waw_p0told got=%0d exp=7", rob_p0told); end
      checks++; if (rob_p1told !== 7'd40) begin failures++; $display("FAIL waw_p1told got=%0d exp=40", rob_p1told); end
      tick();
      rob_ar_a1 = 5'd7;
      #1;
      $display("after waw: r7=%0d/%b", rs_pr_a1, rs_pr_a1_ready);
      checks++; if ({rs_pr_a1, rs_pr_a1_ready} !== {7'd41, 1'b0}) begin failures++; $display("FAIL waw_r7 got=%0d/%b exp=41/0", rs_pr_a1, rs_pr_a1_ready); end
   endtask

   task automatic test_stale_and_override();
      rob_dispatch_num = 2'd1; rob_ar_a_valid = 1'b1; rob_ar_a = 5'd3; fl_pr0 = 7'd36;
      #1;
      checks++; if (rob_p0told !== 7'd32) begin failures++; $display("FAIL stale_p0told got=%0d exp=32", rob_p0told); end
      tick();
      cdb_broadcast = 3'd1; cdb_pr_tag0 = 7'd32; cdb_ar_tag0 = 5'd3;
      tick();
      rob_ar_a1 = 5'd3;
      #1;
      $display("stale cdb: r3=%0d/%b", rs_pr_a1, rs_pr_a1_ready);
      checks++; if ({rs_pr_a1, rs_pr_a1_ready} !== {7'd36, 1'b0}) begin failures++; $display("FAIL stale_r3 got=%0d/%b exp=36/0", rs_pr_a1, rs_pr_a1_ready); end
      // Matching CDB and dispatch on the same AR: dispatch wins.
      cdb_broadcast = 3'd1; cdb_pr_tag0 = 7'd36; cdb_ar_tag0 = 5'd3;
      rob_dispatch_num = 2'd1; rob_ar_a_valid = 1'b1; rob_ar_a = 5'd3; fl_pr0 = 7'd37;
      tick();
      rob_ar_a1 = 5'd3;
      #1;
      $display("cdb vs dispatch: r3=%0d/%b", rs_pr_a1, rs_pr_a1_ready);
      checks++; if ({rs_pr_a1, rs_pr_a1_ready} !== {7'd37, 1'b0}) begin failures++; $display("FAIL override_r3 got=%0d/%b exp=37/0", rs_pr_a1, rs_pr_a1_ready); end
      // Highest slot wakes r3 when all four are valid.
      cdb_broadcast = 3'd4; cdb_pr_tag3 = 7'd37; cdb_ar_tag3 = 5'd3;
      tick();
      rob_ar_a1 = 5'd3;
      #1;
      $display("cdb slot3: r3=%0d/%b", rs_pr_a1, rs_pr_a1_ready);
      checks++; if ({rs_pr_a1, rs_pr_a1_ready} !== {7'd37, 1'b1}) begin failures++; $display("FAIL slot3_r3 got=%0d/%b exp=37/1", rs_pr_a1, rs_pr_a1_ready); end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      rob_dispatch_num = 2'd2; rob_ar_a_valid = 1'b1; rob_ar_b_valid = 1'b1;
      rob_ar_a = 5'd3; rob_ar_b = 5'd31; fl_pr0 = 7'd50; fl_pr1 = 7'd51;
      tick();
      rob_ar_a1 = 5'd3; rob_ar_a2 = 5'd7; rob_ar_b1 = 5'd9; rob_ar_b2 = 5'd31;
      #1;
      $display("mid reset: %0d/%b %0d/%b %0d/%b %0d/%b", rs_pr_a1, rs_pr_a1_ready, rs_pr_a2, rs_pr_a2_ready,
               rs_pr_b1, rs_pr_b1_ready, rs_pr_b2, rs_pr_b2_ready);
      checks++; if ({rs_pr_a1, rs_pr_a2, rs_pr_b1, rs_pr_b2} !== {7'd3, 7'd7, 7'd9, 7'd31}) begin
         failures++; $display("FAIL midreset_tags got=%0d/%0d/%0d/%0d exp=3/7/9/31", rs_pr_a1, rs_pr_a2, rs_pr_b1, rs_pr_b2); end
      checks++; if ({rs_pr_a1_ready, rs_pr_a2_ready, rs_pr_b1_ready, rs_pr_b2_ready} !== 4'b1111) begin
         failures++; $display("FAIL midreset_ready got=%b%b%b%b exp=1111", rs_pr_a1_ready, rs_pr_a2_ready, rs_pr_b1_ready, rs_pr_b2_ready); end
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      @(negedge clock);
      test_reset();
      test_dispatch2();
      test_dispatch1();
      test_cdb();
      test_group_dep();
      test_stale_and_override();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
